// File: rtl/dispatch_pkg.sv
// Shared types and constants for the dual-lane dispatch stage.
// Functional-type codes, FSM state encoding and branch-payload sizing.
package dispatch_pkg;

  localparam logic [1:0] FT_ARITH  = 2'd0;
  localparam logic [1:0] FT_LS     = 2'd1;
  localparam logic [1:0] FT_BRANCH = 2'd2;
  localparam logic [1:0] FT_RSVD   = 2'd3;

  localparam int BR_STAT_W = 2;

  typedef enum logic {
    ISSUE  = 1'b0,
    REPLAY = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    BSEL_A      = 2'd0,
    BSEL_B      = 2'd1,
    BSEL_REPLAY = 2'd2
  } bsel_e;

  typedef struct packed {
    logic arith_a;
    logic arith_b;
    logic ls_a;
    logic ls_b;
    logic branch;
    logic conflict;
    logic illegal;
  } pulse_t;

  // Branch payload is {status, opcode, primary operand, secondary operand}.
  function automatic int br_pl_w(input int opc_w, input int data_w);
    return BR_STAT_W + opc_w + 2 * data_w;
  endfunction

endpackage

// File: rtl/dispatch_branch_select.sv
// Branch payload source mux: lane A, lane B or the held replay branch.
module dispatch_branch_select
  import dispatch_pkg::*;
#(
  parameter int PL_W = 41
) (
  input  bsel_e            sel,
  input  logic [PL_W-1:0]  lane_a,
  input  logic [PL_W-1:0]  lane_b,
  input  logic [PL_W-1:0]  replay,
  output logic [PL_W-1:0]  payload
);

  always_comb begin
    payload = replay;
    case (sel)
      BSEL_A:  payload = lane_a;
      BSEL_B:  payload = lane_b;
      default: payload = replay;
    endcase
  end

endmodule

// File: rtl/dual_lane_dispatch.sv
// Registered two-lane dispatch to arith/LS/branch units with branch-pair replay.
// Optional perf counters enabled by defining DISPATCH_PERF_CNT_EN.
module dual_lane_dispatch
  import dispatch_pkg::*;
#(
  parameter int DATA_W        = 16,
  parameter int OPC_W         = 7,
  parameter int WB_W          = 5,
  parameter int BRANCH_REPLAY = 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              flushBack_i,
  input  logic              stall_i,
  input  logic              inValid_i,
  output logic              inReady_o,
  input  logic              enableA_i,
  input  logic              enableB_i,
  input  logic [1:0]        functionalTypeA_i,
  input  logic [1:0]        functionalTypeB_i,
  input  logic [WB_W-1:0]   wbAddressA_i,
  input  logic [WB_W-1:0]   wbAddressB_i,
  input  logic              isWbA_i,
  input  logic              isWbB_i,
  input  logic [OPC_W-1:0]  opCodeA_i,
  input  logic [OPC_W-1:0]  opCodeB_i,
  input  logic [DATA_W-1:0] pOperandA_i,
  input  logic [DATA_W-1:0] pOperandB_i,
  input  logic [DATA_W-1:0] sOperandA_i,
  input  logic [DATA_W-1:0] sOperandB_i,
  input  logic [1:0]        operationStatusA_i,
  input  logic [1:0]        operationStatusB_i,
  output logic              arithEnableA_o,
  output logic              arithEnableB_o,
  output logic              lsEnableA_o,
  output logic              lsEnableB_o,
  output logic              branchEnable_o,
  output logic              isWbA_o,
  output logic              isWbB_o,
  output logic [WB_W-1:0]   wbAddressA_o,
  output logic [WB_W-1:0]   wbAddressB_o,
  output logic [OPC_W-1:0]  opCodeA_o,
  output logic [OPC_W-1:0]  opCodeB_o,
  output logic [DATA_W-1:0] pOperandA_o,
  output logic [DATA_W-1:0] pOperandB_o,
  output logic [DATA_W-1:0] sOperandA_o,
  output logic [DATA_W-1:0] sOperandB_o,
  output logic [1:0]        opStat_branch_o,
  output logic [OPC_W-1:0]  opCode_branch_o,
  output logic [DATA_W-1:0] pOperand_branch_o,
  output logic [DATA_W-1:0] sOperand_branch_o,
  output logic              branchConflict_o,
  output logic              illegalType_o
`ifdef DISPATCH_PERF_CNT_EN
  ,
  output logic [31:0]       issuedCount_o,
  output logic [31:0]       stallCount_o,
  output logic [15:0]       replayCount_o
`endif
);

  localparam int LANE_W = 1 + WB_W + OPC_W + 2 * DATA_W;
  localparam int BR_W   = br_pl_w(OPC_W, DATA_W);

  state_e            state_p1, state_nxt;
  pulse_t            pulse_nxt, pulse_p1;
  bsel_e             bsel;
  logic [LANE_W-1:0] lane_a_p1, lane_b_p1;
  logic [BR_W-1:0]   br_a, br_b, br_sel, br_p1, replay_p1;
  logic              accept, a_br, b_br, both_br, load_br;

  assign inReady_o = !stall_i && !flushBack_i && (state_p1 == ISSUE);
  assign accept    = inValid_i && inReady_o;
  assign a_br      = enableA_i && (functionalTypeA_i == FT_BRANCH);
  assign b_br      = enableB_i && (functionalTypeB_i == FT_BRANCH);
  assign both_br   = a_br && b_br;
  assign br_a      = {operationStatusA_i, opCodeA_i, pOperandA_i, sOperandA_i};
  assign br_b      = {operationStatusB_i, opCodeB_i, pOperandB_i, sOperandB_i};

  always_comb begin
    bsel = BSEL_B;
    if (state_p1 == REPLAY) bsel = BSEL_REPLAY;
    else if (a_br)          bsel = BSEL_A;
  end

  dispatch_branch_select #(.PL_W(BR_W)) u_branch_select (
    .sel     (bsel),
    .lane_a  (br_a),
    .lane_b  (br_b),
    .replay  (replay_p1),
    .payload (br_sel)
  );

  // p0 -> p1: decode pulses and next state
  always_comb begin
    state_nxt = state_p1;
    pulse_nxt = '0;
    load_br   = 1'b0;
    if (flushBack_i) begin
      state_nxt = ISSUE;
    end else if (!stall_i) begin
      if (state_p1 == REPLAY) begin
        state_nxt        = ISSUE;
        pulse_nxt.branch = 1'b1;
        load_br          = 1'b1;
      end else if (accept) begin
        pulse_nxt.arith_a = enableA_i && (functionalTypeA_i == FT_ARITH);
        pulse_nxt.arith_b = enableB_i && (functionalTypeB_i == FT_ARITH);
        pulse_nxt.ls_a    = enableA_i && (functionalTypeA_i == FT_LS);
        pulse_nxt.ls_b    = enableB_i && (functionalTypeB_i == FT_LS);
        pulse_nxt.branch  = a_br || b_br;
        pulse_nxt.illegal = (enableA_i && (functionalTypeA_i == FT_RSVD)) ||
                            (enableB_i && (functionalTypeB_i == FT_RSVD));
        load_br           = a_br || b_br;
        if (both_br) begin
          if (BRANCH_REPLAY != 0) state_nxt = REPLAY;
          else pulse_nxt.conflict = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_p1  <= ISSUE;
      pulse_p1  <= '0;
      lane_a_p1 <= '0;
      lane_b_p1 <= '0;
      br_p1     <= '0;
      replay_p1 <= '0;
    end else begin
      state_p1 <= state_nxt;
      pulse_p1 <= pulse_nxt;
      if (flushBack_i) begin
        lane_a_p1 <= '0;
        lane_b_p1 <= '0;
        br_p1     <= '0;
        replay_p1 <= '0;
      end else begin
        if (accept) begin
          lane_a_p1 <= {isWbA_i, wbAddressA_i, opCodeA_i, pOperandA_i, sOperandA_i};
          lane_b_p1 <= {isWbB_i, wbAddressB_i, opCodeB_i, pOperandB_i, sOperandB_i};
          if (both_br) replay_p1 <= br_b;
        end
        if (load_br) br_p1 <= br_sel;
      end
    end
  end

  assign {isWbA_o, wbAddressA_o, opCodeA_o, pOperandA_o, sOperandA_o} = lane_a_p1;
  assign {isWbB_o, wbAddressB_o, opCodeB_o, pOperandB_o, sOperandB_o} = lane_b_p1;
  assign {opStat_branch_o, opCode_branch_o, pOperand_branch_o, sOperand_branch_o} = br_p1;
  assign arithEnableA_o   = pulse_p1.arith_a;
  assign arithEnableB_o   = pulse_p1.arith_b;
  assign lsEnableA_o      = pulse_p1.ls_a;
  assign lsEnableB_o      = pulse_p1.ls_b;
  assign branchEnable_o   = pulse_p1.branch;
  assign branchConflict_o = pulse_p1.conflict;
  assign illegalType_o    = pulse_p1.illegal;

`ifdef DISPATCH_PERF_CNT_EN
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [2:0] inc);
    logic [32:0] s;
    s = {1'b0, a} + {30'd0, inc};
    return s[32] ? '1 : s[31:0];
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] a);
    return (a == '1) ? a : a + 16'd1;
  endfunction

  logic [2:0] issued_inc;
  assign issued_inc = {2'b0, pulse_nxt.arith_a} + {2'b0, pulse_nxt.arith_b} +
                      {2'b0, pulse_nxt.ls_a} + {2'b0, pulse_nxt.ls_b} +
                      {2'b0, pulse_nxt.branch};

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      issuedCount_o <= '0;
      stallCount_o  <= '0;
      replayCount_o <= '0;
    end else begin
      issuedCount_o <= sat_add32(issuedCount_o, issued_inc);
      stallCount_o  <= sat_add32(stallCount_o, {2'b0, stall_i});
      if (state_p1 == ISSUE && state_nxt == REPLAY)
        replayCount_o <= sat_inc16(replayCount_o);
    end
  end
`endif

endmodule
